// File: rtl/dds_cmd_pkg.sv
// Shared types and constants for the UART-to-DDS command path.
package dds_cmd_pkg;

   localparam int PHASE_W = 10;
   localparam logic [7:0] CH_BROADCAST = 8'hFF;

   typedef logic [PHASE_W-1:0] phase_t;

   typedef enum logic [2:0] {
      IDLE,
      CH,
      HI,
      LO,
      CK
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CKSUM   = 2'd1,
      ERR_RANGE   = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_e;

   localparam phase_t PHASE_RST_0 = 10'd0;
   localparam phase_t PHASE_RST_1 = 10'd256;
   localparam phase_t PHASE_RST_2 = 10'd512;
   localparam phase_t PHASE_RST_3 = 10'd768;

   function automatic phase_t reset_phase(input logic [1:0] idx);
      phase_t val;
      case (idx)
         2'd0:    val = PHASE_RST_0;
         2'd1:    val = PHASE_RST_1;
         2'd2:    val = PHASE_RST_2;
         default: val = PHASE_RST_3;
      endcase
      return val;
   endfunction

   // Channel must be 0..3 or broadcast, and only two phase bits may come from the high byte.
   function automatic logic range_ok(input logic [7:0] ch, input logic [7:0] hi);
      return ((ch[7:2] == 6'd0) || (ch == CH_BROADCAST)) && (hi[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/phase_frame_parser_if.sv
// Byte input, apply strobe, phase words and frame status between UART side and DDS side.
interface phase_frame_parser_if;
   import dds_cmd_pkg::*;

   logic [7:0] rx_data;
   logic       rx_done;
   logic       apply;
   phase_t     phase_1;
   phase_t     phase_2;
   phase_t     phase_3;
   phase_t     phase_4;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   modport master (
      output rx_data, rx_done, apply,
      input  phase_1, phase_2, phase_3, phase_4, frame_ok, frame_err, err_code
   );

   modport slave (
      input  rx_data, rx_done, apply,
      output phase_1, phase_2, phase_3, phase_4, frame_ok, frame_err, err_code
   );

endinterface

// File: rtl/frame_timeout_ctr.sv
// Inter-byte watchdog: clears on each byte, counts while a frame is open, pulses on expiry.
module frame_timeout_ctr #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A byte arriving in the expiry cycle suppresses the expiry.
   always_comb begin
      expire = run && !clr && (cnt_q == LAST);
      cnt_d  = cnt_q + CNT_W'(1);
      if (clr || !run || expire) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/phase_frame_parser.sv
// Parses HDR/CH/PH_HI/PH_LO/CK frames into four DDS phase offset words.
// Optional PHASE_APPLY_SYNC_EN: accepted values wait in shadow registers until an apply pulse.
module phase_frame_parser
   import dds_cmd_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
   input logic                 clk,
   input logic                 rst_n,
   phase_frame_parser_if.slave bus
);

   state_e     state_q, state_d;
   logic [7:0] ch_q, ch_d;
   logic [7:0] hi_q, hi_d;
   logic [7:0] lo_q, lo_d;
   phase_t     phase_q [4];
   phase_t     phase_d [4];
   phase_t     upd     [4];
   logic       frame_ok_q, frame_ok_d;
   logic       frame_err_q, frame_err_d;
   err_e       err_code_q, err_code_d;
   logic       accept;
   logic       expire;
   logic       run;
   phase_t     new_phase;

   assign run       = (state_q != IDLE);
   assign new_phase = {hi_q[1:0], lo_q};

   frame_timeout_ctr #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst_n),
      .clr    (bus.rx_done),
      .run    (run),
      .expire (expire)
   );

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      accept      = 1'b0;
      if (bus.rx_done) begin
         case (state_q)
            IDLE: if (bus.rx_data == HDR_BYTE) state_d = CH;
            CH: begin
               ch_d    = bus.rx_data;
               state_d = HI;
            end
            HI: begin
               hi_d    = bus.rx_data;
               state_d = LO;
            end
            LO: begin
               lo_d    = bus.rx_data;
               state_d = CK;
            end
            CK: begin
               state_d = IDLE;
               if (bus.rx_data != (ch_q ^ hi_q ^ lo_q)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CKSUM;
               end else if (!range_ok(ch_q, hi_q)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_RANGE;
               end else begin
                  frame_ok_d = 1'b1;
                  accept     = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (expire) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
      end
   end

`ifdef PHASE_APPLY_SYNC_EN
   phase_t shadow_q [4];
   phase_t shadow_d [4];

   // Apply in the acceptance cycle forwards the freshly accepted value.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         upd[i] = shadow_q[i];
         if (accept && ((ch_q == CH_BROADCAST) || (ch_q[1:0] == 2'(i)))) upd[i] = new_phase;
         shadow_d[i] = upd[i];
         phase_d[i]  = bus.apply ? upd[i] : phase_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) shadow_q[i] <= reset_phase(2'(i));
      end else begin
         for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
      end
   end
`else
   logic unused_apply;
   assign unused_apply = bus.apply;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         upd[i] = phase_q[i];
         if (accept && ((ch_q == CH_BROADCAST) || (ch_q[1:0] == 2'(i)))) upd[i] = new_phase;
         phase_d[i] = upd[i];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         for (int i = 0; i < 4; i++) phase_q[i] <= reset_phase(2'(i));
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         for (int i = 0; i < 4; i++) phase_q[i] <= phase_d[i];
      end
   end

   assign bus.phase_1   = phase_q[0];
   assign bus.phase_2   = phase_q[1];
   assign bus.phase_3   = phase_q[2];
   assign bus.phase_4   = phase_q[3];
   assign bus.frame_ok  = frame_ok_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_phase_frame_parser.sv
// Randomized and directed bench for phase_frame_parser against a frame-level reference model.
module tb_phase_frame_parser;

   localparam int         T   = 40;
   localparam logic [7:0] HDR = 8'hA5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   phase_frame_parser_if bus ();

   phase_frame_parser #(
      .TIMEOUT_CYC(T),
      .HDR_BYTE   (HDR)
   ) dut (
      .clk   (clk),
      .rst_n (rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: expected outputs, shadow values, bytes of the open frame, idle gap length.
   int exp_ph [4];
   int shd    [4];
   bit exp_ok, exp_err;
   int exp_code;
   int frm [$];
   bit in_frame;
   int gap;
   bit rand_apply;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         exp_ph[i] = i * 256;
         shd[i]    = i * 256;
      end
      exp_ok   = 1'b0;
      exp_err  = 1'b0;
      exp_code = 0;
      frm.delete();
      in_frame = 1'b0;
      gap      = 0;
   endfunction

   function automatic void model_step(input bit done, input int data, input bit ap, input bit r);
      int tgt [4];
      bit acc;
      exp_ok  = 1'b0;
      exp_err = 1'b0;
      acc     = 1'b0;
`ifdef PHASE_APPLY_SYNC_EN
      for (int i = 0; i < 4; i++) tgt[i] = shd[i];
`else
      for (int i = 0; i < 4; i++) tgt[i] = exp_ph[i];
`endif
      if (r) begin
         model_reset();
         return;
      end
      if (done) begin
         gap = 0;
         if (!in_frame) begin
            if (data == int'(HDR)) begin
               in_frame = 1'b1;
               frm.delete();
            end
         end else begin
            frm.push_back(data);
            if (frm.size() == 4) begin
               in_frame = 1'b0;
               if ((frm[0] ^ frm[1] ^ frm[2]) != frm[3]) begin
                  exp_err  = 1'b1;
                  exp_code = 1;
               end else if (!(((frm[0] <= 3) || (frm[0] == 255)) && (frm[1] <= 3))) begin
                  exp_err  = 1'b1;
                  exp_code = 2;
               end else begin
                  exp_ok = 1'b1;
                  acc    = 1'b1;
                  for (int i = 0; i < 4; i++)
                     if (frm[0] == 255 || frm[0] == i) tgt[i] = frm[1] * 256 + frm[2];
               end
            end
         end
      end else if (in_frame) begin
         gap++;
         if (gap == T) begin
            exp_err  = 1'b1;
            exp_code = 3;
            in_frame = 1'b0;
            gap      = 0;
         end
      end
`ifdef PHASE_APPLY_SYNC_EN
      for (int i = 0; i < 4; i++) shd[i] = tgt[i];
      if (ap) for (int i = 0; i < 4; i++) exp_ph[i] = shd[i];
`else
      if (acc || ap || !ap) for (int i = 0; i < 4; i++) exp_ph[i] = tgt[i];
`endif
   endfunction

   task automatic compare_all();
      check_eq("frame_ok", int'(bus.frame_ok), int'(exp_ok));
      check_eq("frame_err", int'(bus.frame_err), int'(exp_err));
      check_eq("err_code", int'(bus.err_code), exp_code);
      check_eq("phase_1", int'(bus.phase_1), exp_ph[0]);
      check_eq("phase_2", int'(bus.phase_2), exp_ph[1]);
      check_eq("phase_3", int'(bus.phase_3), exp_ph[2]);
      check_eq("phase_4", int'(bus.phase_4), exp_ph[3]);
      check_eq("ok_err_exclusive", int'(bus.frame_ok & bus.frame_err), 0);
   endtask

   task automatic cyc(input bit done, input logic [7:0] data, input bit ap, input bit r);
      @(negedge clk);
      bus.rx_done = done;
      bus.rx_data = data;
      bus.apply   = ap;
      rst         = r;
      @(posedge clk);
      model_step(done, int'(data), ap, r);
      #1;
      compare_all();
   endtask

   function automatic bit pick_apply();
      return rand_apply && ($urandom_range(0, 5) == 0);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int idle);
      cyc(1'b1, b, pick_apply(), 1'b0);
      repeat (idle) cyc(1'b0, 8'($urandom), pick_apply(), 1'b0);
   endtask

   function automatic int pick_gap();
      int r;
      r = int'($urandom_range(0, 24));
      if (r == 0) return T;
      if (r == 1) return T - 1;
      return int'($urandom_range(0, 3));
   endfunction

   task automatic send_frame(input logic [7:0] ch, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] ck, input bit rnd_gap);
      send_byte(HDR, rnd_gap ? pick_gap() : 0);
      send_byte(ch, rnd_gap ? pick_gap() : 0);
      send_byte(hi, rnd_gap ? pick_gap() : 0);
      send_byte(lo, rnd_gap ? pick_gap() : 0);
      send_byte(ck, 0);
   endtask

   task automatic do_reset();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] ch, hi, lo, ck;
      int         ph, kind;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.apply   = 1'b0;
      rand_apply  = 1'b0;
      model_reset();
      do_reset();
      do_reset();
      check_eq("rst_phase_4", int'(bus.phase_4), 768);
      check_eq("rst_err_code", int'(bus.err_code), 0);

`ifndef PHASE_APPLY_SYNC_EN
      send_frame(8'h02, 8'h01, 8'h2C, 8'h2F, 1'b0);
      check_eq("d1_phase_3", int'(bus.phase_3), 300);
      check_eq("d1_ok", int'(bus.frame_ok), 1);
      check_eq("d1_phase_1", int'(bus.phase_1), 0);
      send_frame(8'hFF, 8'h03, 8'hFF, 8'h03, 1'b0);
      check_eq("d2_phase_2", int'(bus.phase_2), 1023);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check_eq("d2_single_ok", int'(bus.frame_ok), 0);
      do_reset();
      send_frame(8'h00, 8'h00, 8'h10, 8'h11, 1'b0);
      check_eq("d3_cksum_code", int'(bus.err_code), 1);
      check_eq("d3_phase_1", int'(bus.phase_1), 0);
      send_frame(8'h00, 8'h04, 8'h00, 8'h04, 1'b0);
      check_eq("d3_range_code", int'(bus.err_code), 2);
      send_byte(8'h3C, 2);
      send_byte(8'h5A, 2);
      send_frame(8'h01, 8'h00, 8'h05, 8'h04, 1'b0);
      check_eq("d4_phase_2", int'(bus.phase_2), 5);
      send_byte(HDR, 0);
      send_byte(8'h01, T);
      check_eq("d5_timeout_err", int'(bus.frame_err), 1);
      check_eq("d5_timeout_code", int'(bus.err_code), 3);
      send_frame(8'h03, 8'h02, 8'h00, 8'h01, 1'b0);
      check_eq("d5_phase_4", int'(bus.phase_4), 512);
      send_byte(HDR, T - 1);
      send_byte(8'h00, T - 1);
      send_byte(8'h00, T - 1);
      send_byte(8'h07, T - 1);
      send_byte(8'h07, 0);
      check_eq("d6_byte_wins", int'(bus.phase_1), 7);
`else
      send_frame(8'h00, 8'h00, 8'h64, 8'h64, 1'b0);
      check_eq("s1_ok", int'(bus.frame_ok), 1);
      check_eq("s1_phase_1_held", int'(bus.phase_1), 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("s1_phase_1_applied", int'(bus.phase_1), 100);
      send_frame(8'h02, 8'h01, 8'h2C, 8'h2F, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("s2_phase_3", int'(bus.phase_3), 300);
      send_byte(HDR, 0);
      send_byte(8'h01, 0);
      cyc(1'b1, 8'h02, 1'b0, 1'b1);
      rst = 1'b0;
      check_eq("s3_rst_phase_1", int'(bus.phase_1), 0);
      check_eq("s3_rst_phase_3", int'(bus.phase_3), 512);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("s3_shadow_rst", int'(bus.phase_3), 512);
`endif

      rand_apply = 1'b1;
      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         ph   = int'($urandom_range(0, 1023));
         ch   = 8'($urandom_range(0, 3));
         hi   = 8'(ph / 256);
         lo   = 8'(ph % 256);
         case (kind)
            4: ch = 8'hFF;
            6: ch = 8'($urandom_range(4, 254));
            7: hi = {6'($urandom_range(1, 63)), hi[1:0]};
            default: ;
         endcase
         ck = ch ^ hi ^ lo;
         if (kind == 5) ck = ck ^ 8'($urandom_range(1, 255));
         if (kind == 8) begin
            send_byte(8'($urandom), pick_gap());
         end else if (kind == 9) begin
            send_byte(HDR, int'($urandom_range(0, 2)));
            send_byte(ch, int'($urandom_range(0, 2)));
            cyc(1'($urandom), 8'($urandom), 1'b0, 1'b1);
            rst = 1'b0;
         end else begin
            send_frame(ch, hi, lo, ck, 1'b1);
         end
         repeat ($urandom_range(0, 2)) cyc(1'b0, 8'($urandom), pick_apply(), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_frame_parser.md
Name: phase_frame_parser

Overview:
- Byte-level command parser between the UART receiver and the four-channel DDS sine generator.
- Consumes received bytes with a done strobe and assembles fixed-format frames.
- On a valid frame, updates one or all of four 10-bit phase offset words consumed by the DDS stage.
- Reports frame success or failure with one-cycle status pulses.

Parameters:
- TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles while a frame is in progress.
- HDR_BYTE, 8'hA5, frame header value.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-high; the port keeps the codebase's reset name.
- rx_data  input  8  received byte; valid only in the cycle rx_done is high.
- rx_done  input  1  one-cycle strobe from the UART receiver.
- apply  input  1  synchronous update strobe; used only when the optional feature is compiled in.
- phase_1, phase_2, phase_3, phase_4  output  10 each  phase offset words for DDS channels 0..3.
- frame_ok  output  1  one-cycle pulse when a frame is accepted.
- frame_err  output  1  one-cycle pulse when a frame is rejected.
- err_code  output  2  cause of the last rejection: 1 = checksum, 2 = range, 3 = timeout. Held until the next rejection.

Behaviour:
- Frame format, 5 bytes: HDR_BYTE, CH, PH_HI, PH_LO, CK.
  - CK = CH ^ PH_HI ^ PH_LO.
  - phase value = {PH_HI[1:0], PH_LO}.
- CH selects the target channel:
  - 0..3 selects phase_1..phase_4.
  - 8'hFF is broadcast to all four channels.
  - Any other value is a range error.
  - PH_HI[7:2] != 0 is also a range error.
- Reset values (synchronous reset, all registers):
  - phase_1=0, phase_2=256, phase_3=512, phase_4=768.
  - frame_ok=0, frame_err=0, err_code=0.
  - State = IDLE, timeout counter = 0.
- State machine: IDLE -> CH -> HI -> LO -> CK -> IDLE. A state advances only on rx_done.
  - IDLE: a byte equal to HDR_BYTE goes to CH. Any other byte is discarded silently with no error.
  - CH, HI, LO: latch the byte and advance.
  - CK: perform checks and return to IDLE in the same transition.
- Checks at the CK byte, in priority order:
  1. Checksum mismatch -> err 1.
  2. Range error -> err 2.
  3. Otherwise accept the frame.
- Latency: rx_done of the CK byte in cycle N gives frame_ok or frame_err high in cycle N+1. On acceptance, the phase outputs take their new values in cycle N+1.
- Rejected frames never modify the phase outputs.
- No mid-frame resync: a HDR_BYTE value received inside a frame is treated as data.
- Timeout:
  - The counter clears on every rx_done and counts while the state is not IDLE.
  - When it reaches TIMEOUT_CYC-1 with no rx_done: go to IDLE, pulse frame_err with err_code=3, clear the counter.
  - If rx_done arrives in the same cycle the count is reached, the byte wins and no timeout occurs.
- Reset asserted mid-frame: return to IDLE and restore the reset phase values. Any rx_done in that cycle is ignored.
- frame_ok and frame_err are never high in the same cycle.

Optional Feature:
- Macro: PHASE_APPLY_SYNC_EN.
- Defined:
  - Accepted values are written to four shadow registers; outputs do not change at acceptance.
  - An apply pulse in cycle M copies all shadows to the outputs in cycle M+1.
  - Shadows reset to the same values as the outputs.
  - If apply and an acceptance occur in the same cycle, the outputs take the newly accepted value.
- Undefined: apply is ignored and outputs update as described in Behaviour.

Decomposition:
- Shared package dds_cmd_pkg holds:
  - State enum: IDLE, CH, HI, LO, CK.
  - Error codes: ERR_NONE, ERR_CKSUM, ERR_RANGE, ERR_TIMEOUT.
  - CH_BROADCAST = 8'hFF.
  - PHASE_W = 10.
  - Reset phase constants 0, 256, 512, 768.
- One sub-module, frame_timeout_ctr: counter, clear input, run enable, expiry pulse output.

Test Plan:
- Send A5 02 01 2C 2F -> cycle after the CK byte: phase_3=300, frame_ok=1; other phases keep reset values.
- Send A5 FF 03 FF 03 -> all four phases=1023, single frame_ok pulse.
- Send A5 00 00 10 11 (bad checksum) -> frame_err=1, err_code=1, phase_1 remains 0. Send A5 00 04 00 04 -> err_code=2 (range).
- Send 3C 5A (no header), then A5 01 00 05 04 -> no error pulses for the stray bytes; phase_2=5.
- Send A5 01, then idle for TIMEOUT_CYC cycles -> frame_err with err_code=3. A following full valid frame is accepted.
- With PHASE_APPLY_SYNC_EN defined:
  - Accept A5 00 00 64 64 -> phase_1 stays 0.
  - Pulse apply -> phase_1=100 the next cycle.
  - Assert reset mid-frame -> all phases return to 0/256/512/768.
